// File: rtl/register_bank_if.sv
// register_bank_if: bus bundle for register_bank.
//   enable  - per-register operation enable (bit i -> register i)
//   funsel  - operation code applied to every enabled register
//   load    - parallel load data
//   sel_a/b - read-port register indices
//   Q_a/Q_b - read-port data (combinational from stored contents)
//   carry   - registered wrap / shift-out flag
//   zero    - high when Q_a is zero
// The bus has no handshake. Inputs are sampled on every rising clock edge,
// and the outputs follow the stored state.
interface register_bank_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  enable;
    logic [2:0]        funsel;
    logic [N-1:0]      load;
    logic [ADDR_W-1:0] sel_a;
    logic [ADDR_W-1:0] sel_b;
    logic [N-1:0]      Q_a;
    logic [N-1:0]      Q_b;
    logic              carry;
    logic              zero;

    modport master (
        output enable, funsel, load, sel_a, sel_b,
        input  Q_a, Q_b, carry, zero
    );

    modport slave (
        input  enable, funsel, load, sel_a, sel_b,
        output Q_a, Q_b, carry, zero
    );
endinterface

// File: rtl/register_bank.sv
// register_bank: DEPTH independent N-bit registers sharing one operation code.
// Each enabled register applies funsel to its own pre-edge value. Two
// combinational read ports and a zero flag on port A are provided. The carry
// flag collects wrap/shift-out bits and updates only on arithmetic and shift
// operations.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-high reset (clears registers and carry)
//   bus   - register_bank_if slave modport (see interface header)
module register_bank #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    register_bank_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [N-1:0]    ONE       = N'(1);

    localparam logic [2:0] FS_CLR  = 3'b000;
    localparam logic [2:0] FS_LOAD = 3'b001;
    localparam logic [2:0] FS_DEC  = 3'b010;
    localparam logic [2:0] FS_INC  = 3'b011;
    localparam logic [2:0] FS_SHL  = 3'b100;
    localparam logic [2:0] FS_ASR  = 3'b101;
    localparam logic [2:0] FS_ROL  = 3'b110;

    logic [N-1:0] regs      [DEPTH];
    logic [N-1:0] regs_next [DEPTH];
    logic         carry_q;
    logic         carry_next;
    logic         carry_upd;

    // Next-state per register; carry_next ORs the shift-out/wrap bits of all
    // enabled registers.
    always_comb begin
        carry_next = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            regs_next[i] = regs[i];
            if (bus.enable[i]) begin
                case (bus.funsel)
                    FS_CLR:  regs_next[i] = '0;
                    FS_LOAD: regs_next[i] = bus.load;
                    FS_DEC: begin
                        regs_next[i] = regs[i] - ONE;
                        carry_next   = carry_next | ~(|regs[i]);
                    end
                    FS_INC: begin
                        regs_next[i] = regs[i] + ONE;
                        carry_next   = carry_next | (&regs[i]);
                    end
                    FS_SHL: begin
                        regs_next[i] = {regs[i][N-2:0], 1'b0};
                        carry_next   = carry_next | regs[i][N-1];
                    end
                    FS_ASR: begin
                        regs_next[i] = {regs[i][N-1], regs[i][N-1:1]};
                        carry_next   = carry_next | regs[i][0];
                    end
                    FS_ROL:  regs_next[i] = {regs[i][N-2:0], regs[i][N-1]};
                    default: regs_next[i] = regs[i];
                endcase
            end
        end
    end

    // Carry only reflects operations that can produce a wrap or shift-out.
    assign carry_upd = (|bus.enable) &&
                       ((bus.funsel == FS_DEC) || (bus.funsel == FS_INC) ||
                        (bus.funsel == FS_SHL) || (bus.funsel == FS_ASR));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            carry_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= regs_next[i];
            end
            if (carry_upd) begin
                carry_q <= carry_next;
            end
        end
    end

    // Reads come from stored contents, so they show post-edge values. An index
    // at or above DEPTH reads as zero.
    always_comb begin
        bus.Q_a = '0;
        if ({1'b0, bus.sel_a} < DEPTH_LIM) begin
            bus.Q_a = regs[bus.sel_a];
        end
    end

    always_comb begin
        bus.Q_b = '0;
        if ({1'b0, bus.sel_b} < DEPTH_LIM) begin
            bus.Q_b = regs[bus.sel_b];
        end
    end

    assign bus.zero  = ~(|bus.Q_a);
    assign bus.carry = carry_q;
endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter N, default 8, meaning data width of every register (N >= 2).
REQ-002 Parameter DEPTH, default 4, meaning number of registers (DEPTH >= 2); ADDR_W = ceil(log2(DEPTH)) is derived, not overridable.
REQ-003 clock  input  1  meaning sole clock, all state changes on rising edge.
REQ-004 reset  input  1  meaning synchronous, active-high reset.
REQ-005 enable  input  DEPTH  meaning per-register operation enable, bit i selects register i.
REQ-006 funsel  input  3  meaning operation code applied to every enabled register.
REQ-007 load  input  N  meaning parallel load data.
REQ-008 sel_a  input  ADDR_W  meaning read-port A register index.
REQ-009 sel_b  input  ADDR_W  meaning read-port B register index.
REQ-010 Q_a  output  N  meaning contents of register sel_a.
REQ-011 Q_b  output  N  meaning contents of register sel_b.
REQ-012 carry  output  1  meaning registered wrap/shift-out flag.
REQ-013 zero  output  1  meaning Q_a equals zero.

Function
REQ-014 Register i SHALL update on a rising edge only when enable[i]=1 and reset=0; otherwise it SHALL hold.
REQ-015 funsel decode SHALL be: 000 clear to 0; 001 load; 010 decrement; 011 increment; 100 logical shift left (LSB<-0); 101 arithmetic shift right (MSB kept); 110 rotate left; 111 hold.
REQ-016 Increment/decrement SHALL be modulo 2^N: all-ones+1 -> 0, 0-1 -> all-ones.
REQ-017 Every enabled register SHALL compute from its own pre-edge value; registers are independent, no cross-register data flow.
REQ-018 carry SHALL update only on edges where enable != 0 and funsel is 010, 011, 100 or 101; it SHALL hold on all other edges (including funsel 000, 001, 110, 111 or enable = 0).
REQ-019 When updated, carry SHALL equal OR over enabled registers of: increment wrap (old = all-ones), decrement borrow (old = 0), shift-left old MSB, shift-right old LSB.
REQ-020 Q_a and Q_b SHALL be combinational reads of stored contents, showing post-edge values in the same cycle as an update; no write-to-read bypass of pre-edge data.
REQ-021 sel_a or sel_b >= DEPTH (non-power-of-two DEPTH) SHALL read as 0.
REQ-022 sel_a = sel_b SHALL be legal; both ports return identical data.
REQ-023 zero SHALL be combinational: 1 exactly when Q_a = 0 (including out-of-range sel_a).
REQ-024 enable = all-zeros SHALL leave all registers and carry unchanged for any funsel.

Reset
REQ-025 reset=1 at a rising edge SHALL force all registers to 0 and carry to 0, overriding enable and funsel.
REQ-026 After reset, Q_a = Q_b = 0 and zero = 1 until the first enabled non-zero update.
REQ-027 Reset asserted mid-sequence SHALL discard the operation presented that cycle; operation resumes on the first edge with reset=0.

Verification (N=8, DEPTH=4)
REQ-028 Reset, then enable=4'b0001, funsel=001, load=8'h95, sel_a=0 -> Q_a=8'h95, zero=0, other registers 0.
REQ-029 R0=8'hFF, enable=4'b0001, funsel=011 -> R0=8'h00, carry=1, zero=1; next edge funsel=010 -> R0=8'hFF, carry=1; next funsel=011 from 8'hFF->8'h00 repeat, then funsel=011 from 0 -> 8'h01, carry=0.
REQ-030 R0=8'h95, funsel=101 -> 8'hCA, carry=1; funsel=100 -> 8'h94, carry=1; funsel=110 on 8'h94 -> 8'h29, carry unchanged.
REQ-031 R1=8'h10, R2=8'h00, enable=4'b0110, funsel=010 -> R1=8'h0F, R2=8'hFF, carry=1; R0, R3 unchanged; sel_a=1, sel_b=2 read 8'h0F/8'hFF.
REQ-032 funsel=111 or enable=0 with carry=1 -> all registers and carry unchanged for 3 edges.
REQ-033 reset=1 together with enable=4'b1111, funsel=001, load=8'hAA -> all registers 0, carry 0; next edge reset=0 same inputs -> all registers 8'hAA.
